// File: rtl/key_dir_ctrl.sv
// key_dir_ctrl: debounces four direction keys and a start/pause key and drives the held
// direction code and run enable. Build macro KEY_LOCK_REVERSE_EN rejects reversing presses.

module key_db #(
   parameter int DB_CYCLES = 500_000,
   parameter int CNT_W     = 19
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic press_o,
   output logic idle_o
);
   // REL/PRESS_WAIT carry a released stable level, PRESSED/REL_WAIT a pressed one.
   typedef enum logic [1:0] {REL, PRESS_WAIT, PRESSED, REL_WAIT} state_e;

   state_e           state_q, state_d;
   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             s, done;

   assign s       = sync_q[1];
   assign done    = (cnt_q == CNT_W'(DB_CYCLES - 1));
   assign press_o = press_q;
   assign idle_o  = (state_q == REL) || (state_q == PRESS_WAIT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         state_q <= REL;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_n_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   // Counter runs only while the synced level disagrees with the stable level.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      press_d = 1'b0;
      case (state_q)
         REL, PRESS_WAIT: begin
            if (s) begin
               state_d = REL;
            end else if (done) begin
               state_d = PRESSED;
               press_d = 1'b1;
            end else begin
               state_d = PRESS_WAIT;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         PRESSED, REL_WAIT: begin
            if (!s) begin
               state_d = PRESSED;
            end else if (done) begin
               state_d = REL;
            end else begin
               state_d = REL_WAIT;
               cnt_d   = cnt_q + 1'b1;
            end
         end
      endcase
   end
endmodule

module key_dir_ctrl #(
   parameter int DB_CYCLES = 500_000,
   parameter int CNT_W     = 19
) (
   input  logic       vga_clk,
   input  logic       sys_rst,
   input  logic [3:0] key_dir_n,
   input  logic       key_sta_n,
   output logic [3:0] direct_x,
   output logic       sta_en,
   output logic       key_evt
);
   logic [4:0] keys_n, press, idle;
   logic [3:0] dir_q, dir_d;
   logic       sta_q, sta_d, evt_q, evt_d;

   assign keys_n = {key_sta_n, key_dir_n};

   for (genvar i = 0; i < 5; i++) begin : g_key
      key_db #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db (
         .clk_i   (vga_clk),
         .rst_i   (sys_rst),
         .key_n_i (keys_n[i]),
         .press_o (press[i]),
         .idle_o  (idle[i])
      );
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         dir_q <= 4'b1111;
         sta_q <= 1'b0;
         evt_q <= 1'b0;
      end else begin
         dir_q <= dir_d;
         sta_q <= sta_d;
         evt_q <= evt_d;
      end
   end

   // A press wins only if it is the sole event and every other direction key is released.
   always_comb begin
      dir_d = dir_q;
      sta_d = sta_q ^ press[4];
      evt_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ((press[3:0] == (4'b0001 << i)) && ((idle[3:0] | (4'b0001 << i)) == 4'b1111)
`ifdef KEY_LOCK_REVERSE_EN
             && dir_q[3-i]
`endif
            ) begin
            dir_d = ~(4'b0001 << i);
            evt_d = 1'b1;
         end
      end
   end

   assign direct_x = dir_q;
   assign sta_en   = sta_q;
   assign key_evt  = evt_q;
endmodule

// File: tb/tb_key_dir_ctrl.sv
// Scoreboard bench for key_dir_ctrl: a window-based reference model predicts every cycle's
// outputs, a negedge monitor pops and compares them.

module tb_key_dir_ctrl;
   localparam int DB = 8;

   logic       vga_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [3:0] key_dir_n = 4'hF;
   logic       key_sta_n = 1'b1;
   logic [3:0] direct_x;
   logic       sta_en, key_evt;

   key_dir_ctrl #(
      .DB_CYCLES (DB),
      .CNT_W     (4)
   ) dut (
      .vga_clk   (vga_clk),
      .sys_rst   (sys_rst),
      .key_dir_n (key_dir_n),
      .key_sta_n (key_sta_n),
      .direct_x  (direct_x),
      .sta_en    (sta_en),
      .key_evt   (key_evt)
   );

   always #20 vga_clk = ~vga_clk;

   typedef struct packed {
      logic [3:0] dir;
      logic       sta;
      logic       evt;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic logic [3:0] code(input int i);
      return ~(4'b0001 << i);
   endfunction

   // Reference model: a key's stable level flips once the DB raw samples taken from
   // DB+1 to 2 edges ago all disagree with it (two edges of synchronizer delay).
   logic [15:0] hist [5];
   bit          st   [5];
   bit          pend [5];
   logic [3:0]  m_dir;
   bit          m_sta, m_evt, lock_ok, others_rel;
   logic [4:0]  raw;
   logic [DB-1:0] win;
   int          npend;
   exp_t        e_push;

   initial forever begin
      @(posedge vga_clk);
      raw   = {key_sta_n, key_dir_n};
      m_evt = 1'b0;
      if (sys_rst) begin
         m_dir = 4'hF;
         m_sta = 1'b0;
         for (int k = 0; k < 5; k++) begin
            hist[k] = '1;
            st[k]   = 1'b1;
            pend[k] = 1'b0;
         end
      end else begin
         npend = 0;
         for (int i = 0; i < 4; i++) if (pend[i]) npend++;
         for (int i = 0; i < 4; i++) begin
            others_rel = 1'b1;
            for (int j = 0; j < 4; j++) if (j != i && !st[j]) others_rel = 1'b0;
`ifdef KEY_LOCK_REVERSE_EN
            lock_ok = (m_dir != code(3 - i));
`else
            lock_ok = 1'b1;
`endif
            if (pend[i] && npend == 1 && others_rel && lock_ok) begin
               m_dir = code(i);
               m_evt = 1'b1;
            end
         end
         if (pend[4]) m_sta = !m_sta;
         for (int k = 0; k < 5; k++) begin
            hist[k] = {hist[k][14:0], raw[k]};
            win     = hist[k][DB+1:2];
            pend[k] = 1'b0;
            if (st[k] && win == '0) begin
               st[k]   = 1'b0;
               pend[k] = 1'b1;
            end else if (!st[k] && win == '1) begin
               st[k] = 1'b1;
            end
         end
      end
      e_push.dir = m_dir;
      e_push.sta = m_sta;
      e_push.evt = m_evt;
      sb_q.push_back(e_push);
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   exp_t e_pop;
   initial forever begin
      @(negedge vga_clk);
      if (sb_q.size() != 0) begin
         e_pop = sb_q.pop_front();
         check("direct_x", direct_x, e_pop.dir);
         check("sta_en", {3'b000, sta_en}, {3'b000, e_pop.sta});
         check("key_evt", {3'b000, key_evt}, {3'b000, e_pop.evt});
      end
   end

   task automatic drive(input logic [3:0] d, input logic s, input int n);
      key_dir_n = d;
      key_sta_n = s;
      repeat (n) @(negedge vga_clk);
   endtask

   task automatic do_reset(input int n);
      sys_rst = 1'b1;
      repeat (n) @(negedge vga_clk);
      sys_rst = 1'b0;
   endtask

   int r;
   logic [3:0] rd;

   initial begin
      @(negedge vga_clk);
      do_reset(3);
      drive(4'hF, 1'b1, 5);
      // single up press, then release
      drive(4'b1110, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      // bouncing left key, then held
      for (int t = 0; t < 10; t++) drive({2'b11, t[0], 1'b1}, 1'b1, 3);
      drive(4'b1101, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      // start key twice
      drive(4'hF, 1'b0, 20);
      drive(4'hF, 1'b1, 20);
      drive(4'hF, 1'b0, 20);
      drive(4'hF, 1'b1, 20);
      // two keys on the same cycle
      drive(4'b1100, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      // up then down (reverse)
      drive(4'b1110, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      drive(4'b0111, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      // left pressed while up still held, and re-press of the current direction
      drive(4'b1110, 1'b1, 14);
      drive(4'b1100, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      drive(4'b1110, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      // reset in the middle of a debounce
      drive(4'b1011, 1'b1, 6);
      do_reset(2);
      drive(4'b1011, 1'b1, 20);
      drive(4'hF, 1'b1, 20);
      // randomized traffic with bounces, overlaps and occasional resets
      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 19);
         if (r < 8) begin
            rd = code($urandom_range(0, 3));
            drive(rd, 1'b1, $urandom_range(1, 14));
         end else if (r < 10) begin
            rd = code($urandom_range(0, 3)) & code($urandom_range(0, 3));
            drive(rd, 1'b1, $urandom_range(1, 14));
         end else if (r < 12) begin
            drive(key_dir_n, 1'b0, $urandom_range(1, 14));
         end else if (r < 17) begin
            drive(4'hF, 1'b1, $urandom_range(1, 14));
         end else if (r < 19) begin
            rd = 4'($urandom);
            drive(rd, 1'($urandom), $urandom_range(1, 6));
         end else begin
            do_reset($urandom_range(1, 2));
         end
      end
      drive(4'hF, 1'b1, 30);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
